updown_seq_decoder: RTL and testbench

Receive-side companion to the 2-bit synchronous up/down JK counter. Samples the counter's 2-bit binary output `q_in` and recovers the counting direction. Also reports a one-cycle step pulse per observed transition and accumulates a signed position. Flags illegal transitions, where the code skips by two, and sits between a counter-driven source and downstream position or diagnostic logic.

---
 rtl/updown_seq_decoder_if.sv | 25 ++
 rtl/updown_seq_decoder.sv | 129 ++++++++++++
 tb/tb_updown_seq_decoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/updown_seq_decoder_if.sv
// Sample/status bundle between a counter-driven source and the up/down decoder.
// The source drives the sample and clear; the decoder drives the recovered status.
interface updown_seq_decoder_if #(
    parameter int POS_W = 8
);
    logic             valid;
    logic [1:0]       q_in;
    logic             clr;
    logic             step;
    logic             dir;
    logic [POS_W-1:0] pos;
    logic             err;
    logic             locked;
    logic [7:0]       dir_chg_cnt;

    modport master (
        output valid, q_in, clr,
        input  step, dir, pos, err, locked, dir_chg_cnt
    );

    modport slave (
        input  valid, q_in, clr,
        output step, dir, pos, err, locked, dir_chg_cnt
    );
endinterface

// File: rtl/updown_seq_decoder.sv
// Recovers direction, step pulses and signed position from a 2-bit up/down counter.
// Optional macro UPDOWN_DEC_DIRCHG_CNT_EN enables the direction-reversal counter.
module updown_seq_decoder #(
    parameter int POS_W = 8
) (
    input logic                 clk,
    input logic                 reset,
    updown_seq_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       prev_q, prev_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [1:0]       delta;

    assign delta = bus.q_in - prev_q;

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        err_d    = err_q;
        locked_d = locked_q;
        pos_d    = pos_q;
        if (bus.clr) begin
            // Direction survives a clear; the sample in this cycle is dropped.
            state_d  = ACQ;
            err_d    = 1'b0;
            locked_d = 1'b0;
            pos_d    = '0;
        end else if (bus.valid) begin
            unique case (state_q)
                ACQ: begin
                    prev_d   = bus.q_in;
                    state_d  = TRACK;
                    locked_d = 1'b1;
                end
                TRACK: begin
                    prev_d = bus.q_in;
                    unique case (delta)
                        2'd1: begin
                            step_d = 1'b1;
                            dir_d  = 1'b0;
                            pos_d  = pos_q + POS_W'(1);
                        end
                        2'd3: begin
                            step_d = 1'b1;
                            dir_d  = 1'b1;
                            pos_d  = pos_q - POS_W'(1);
                        end
                        2'd2: begin
                            err_d    = 1'b1;
                            locked_d = 1'b0;
                            state_d  = FAULT;
                        end
                        default: ;
                    endcase
                end
                FAULT: ;
                default: state_d = ACQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ACQ;
            prev_q   <= 2'b00;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            pos_q    <= pos_d;
        end
    end

`ifdef UPDOWN_DEC_DIRCHG_CNT_EN
    logic       seen_q;
    logic [7:0] cnt_q;

    // seen_q marks that a step has occurred since acquisition, so the first never counts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seen_q <= 1'b0;
            cnt_q  <= 8'd0;
        end else if (bus.clr) begin
            seen_q <= 1'b0;
            cnt_q  <= 8'd0;
        end else if (bus.valid && state_q == ACQ) begin
            seen_q <= 1'b0;
        end else if (step_d) begin
            seen_q <= 1'b1;
            if (seen_q && dir_d != dir_q && cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign bus.dir_chg_cnt = cnt_q;
`else
    assign bus.dir_chg_cnt = 8'd0;
`endif

    assign bus.step   = step_q;
    assign bus.dir    = dir_q;
    assign bus.pos    = pos_q;
    assign bus.err    = err_q;
    assign bus.locked = locked_q;

endmodule

// File: tb/tb_updown_seq_decoder.sv
// Scoreboard bench for updown_seq_decoder: directed samples, queued expectations,
// and a monitor that checks the registered outputs one cycle after each sample.
module tb_updown_seq_decoder;

    logic clk;
    logic reset;

    updown_seq_decoder_if #(.POS_W(8)) bus ();

    updown_seq_decoder #(.POS_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [19:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] ce(input int x);
`ifdef UPDOWN_DEC_DIRCHG_CNT_EN
        return 8'(x);
`else
        return 8'd0 & 8'(x);
`endif
    endfunction

    // One cycle: drive inputs away from the edge and queue the post-edge outputs.
    task automatic cyc(
        input logic       r,
        input logic       v,
        input logic       c,
        input logic [1:0] q,
        input logic       es,
        input logic       ed,
        input logic [7:0] ep,
        input logic       ee,
        input logic       el,
        input logic [7:0] ec,
        input string      nm
    );
        exp_t e;
        @(negedge clk);
        reset     = r;
        bus.valid = v;
        bus.clr   = c;
        bus.q_in  = q;
        e.v  = {es, ed, ep, ee, el, ec};
        e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: outputs are registered every cycle, so each queued entry is due at the next edge.
    initial begin
        exp_t        e;
        logic [19:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                act = {bus.step, bus.dir, bus.pos, bus.err, bus.locked, bus.dir_chg_cnt};
                n_chk++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got step=%b dir=%b pos=%h err=%b lk=%b cnt=%h want step=%b dir=%b pos=%h err=%b lk=%b cnt=%h",
                             e.nm, act[19], act[18], act[17:10], act[9], act[8], act[7:0],
                             e.v[19], e.v[18], e.v[17:10], e.v[9], e.v[8], e.v[7:0]);
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        bus.valid = 1'b0;
        bus.clr   = 1'b0;
        bus.q_in  = 2'b00;

        cyc(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 0, ce(0), "reset0");
        cyc(0, 0, 0, 2'd0, 0, 0, 8'h00, 0, 0, ce(0), "reset1");

        cyc(1, 1, 0, 2'd0, 0, 0, 8'h00, 0, 1, ce(0), "acq00");
        cyc(1, 1, 0, 2'd1, 1, 0, 8'h01, 0, 1, ce(0), "up01");
        cyc(1, 1, 0, 2'd2, 1, 0, 8'h02, 0, 1, ce(0), "up10");
        cyc(1, 1, 0, 2'd3, 1, 0, 8'h03, 0, 1, ce(0), "up11");
        cyc(1, 1, 0, 2'd0, 1, 0, 8'h04, 0, 1, ce(0), "up00");

        cyc(1, 1, 0, 2'd0, 0, 0, 8'h04, 0, 1, ce(0), "hold_same");
        cyc(1, 0, 0, 2'd1, 0, 0, 8'h04, 0, 1, ce(0), "gap1");
        cyc(1, 0, 0, 2'd2, 0, 0, 8'h04, 0, 1, ce(0), "gap2");
        cyc(1, 1, 0, 2'd0, 0, 0, 8'h04, 0, 1, ce(0), "hold_again");

        cyc(1, 1, 1, 2'd1, 0, 0, 8'h00, 0, 0, ce(0), "clr_dn");
        cyc(1, 1, 0, 2'd0, 0, 0, 8'h00, 0, 1, ce(0), "acq_dn");
        cyc(1, 1, 0, 2'd3, 1, 1, 8'hFF, 0, 1, ce(0), "dn11");
        cyc(1, 1, 0, 2'd2, 1, 1, 8'hFE, 0, 1, ce(0), "dn10");
        cyc(1, 1, 0, 2'd1, 1, 1, 8'hFD, 0, 1, ce(0), "dn01");

        cyc(1, 1, 1, 2'd0, 0, 1, 8'h00, 0, 0, ce(0), "clr_dc");
        cyc(1, 1, 0, 2'd0, 0, 1, 8'h00, 0, 1, ce(0), "acq_dc");
        cyc(1, 1, 0, 2'd1, 1, 0, 8'h01, 0, 1, ce(0), "dc_up1");
        cyc(1, 1, 0, 2'd2, 1, 0, 8'h02, 0, 1, ce(0), "dc_up2");
        cyc(1, 1, 0, 2'd1, 1, 1, 8'h01, 0, 1, ce(1), "dc_dn1");
        cyc(1, 1, 0, 2'd2, 1, 0, 8'h02, 0, 1, ce(2), "dc_up3");
        cyc(1, 1, 0, 2'd1, 1, 1, 8'h01, 0, 1, ce(3), "dc_dn2");

        cyc(1, 1, 1, 2'd0, 0, 1, 8'h00, 0, 0, ce(0), "clr_il");
        cyc(1, 1, 0, 2'd1, 0, 1, 8'h00, 0, 1, ce(0), "acq01");
        cyc(1, 1, 0, 2'd2, 1, 0, 8'h01, 0, 1, ce(0), "il_up");
        cyc(1, 1, 0, 2'd0, 0, 0, 8'h01, 1, 0, ce(0), "skip");
        cyc(1, 1, 0, 2'd1, 0, 0, 8'h01, 1, 0, ce(0), "fault_ign1");
        cyc(1, 1, 0, 2'd3, 0, 0, 8'h01, 1, 0, ce(0), "fault_ign2");
        cyc(1, 0, 0, 2'd0, 0, 0, 8'h01, 1, 0, ce(0), "fault_gap");
        cyc(1, 0, 1, 2'd0, 0, 0, 8'h00, 0, 0, ce(0), "clr_fault");
        cyc(1, 1, 0, 2'd2, 0, 0, 8'h00, 0, 1, ce(0), "reacq10");

        cyc(1, 1, 1, 2'd0, 0, 0, 8'h00, 0, 0, ce(0), "clr_wrap");
        cyc(1, 1, 0, 2'd0, 0, 0, 8'h00, 0, 1, ce(0), "acq_wrap");
        for (int i = 0; i < 128; i++) begin
            cyc(1, 1, 0, 2'(i + 1), 1, 0, 8'(i + 1), 0, 1, ce(0), "wrap_up");
        end
        cyc(1, 1, 1, 2'd1, 0, 0, 8'h00, 0, 0, ce(0), "clr_prio");
        cyc(1, 0, 0, 2'd1, 0, 0, 8'h00, 0, 0, ce(0), "no_acq");
        cyc(1, 1, 0, 2'd0, 0, 0, 8'h00, 0, 1, ce(0), "acq_under");
        cyc(1, 1, 0, 2'd3, 1, 1, 8'hFF, 0, 1, ce(0), "underflow");

        cyc(0, 1, 1, 2'd0, 0, 0, 8'h00, 0, 0, ce(0), "mid_reset");
        cyc(1, 0, 0, 2'd0, 0, 0, 8'h00, 0, 0, ce(0), "post_reset");

        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
